// File: rtl/eth_rx_addr_filter.sv
// Receive-side destination MAC filter: holds the first six bytes of each frame, decides
// forward/discard, and replays accepted frames unchanged with a six-byte delay.
module eth_rx_addr_filter #(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic [7:0]             m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tuser,
    input  logic [47:0]            local_mac,
    input  logic                   promisc,
    input  logic                   accept_bcast,
    input  logic                   accept_mcast,
    output logic [COUNT_WIDTH-1:0] cnt_accepted,
    output logic [COUNT_WIDTH-1:0] cnt_dropped,
    output logic [COUNT_WIDTH-1:0] cnt_runt,
    output logic [COUNT_WIDTH-1:0] cnt_bad,
    output logic [COUNT_WIDTH-1:0] cnt_overrun
);

    typedef enum logic [2:0] {StIdle, StHdr, StPass, StFlush, StDrop} state_e;

    state_e           state_q, state_d;
    logic [5:0][7:0]  hdr_q, hdr_d;
    logic [2:0]       idx_q, idx_d, fcnt_q, fcnt_d;
    logic             uc_q, uc_d, bc_q, bc_d, mc_q, mc_d;
    logic             tuser_q, tuser_d;
    logic             ovr_pend_q, ovr_pend_d, ovr_q, ovr_d;
    logic [7:0]       m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d, m_tuser_q, m_tuser_d;
    logic             inc_acc, inc_drop, inc_runt, inc_bad, inc_ovr;
    logic [COUNT_WIDTH-1:0] acc_q, drop_q, runt_q, bad_q, ovr_cnt_q;

    logic [47:0] mac_sh;
    logic [7:0]  mac_byte;
    logic        first, uc_n, bc_n, mc_n, accept, pend_n;
    logic [47:0] hdr_shift;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                      input logic en);
        return (en && (v != '1)) ? v + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : v;
    endfunction

    always_comb begin
        mac_sh    = local_mac << {idx_q, 3'b000};
        mac_byte  = mac_sh[47:40];
        first     = (state_q == StIdle);
        uc_n      = (first | uc_q) & (s_axis_tdata == mac_byte);
        bc_n      = (first | bc_q) & (s_axis_tdata == 8'hFF);
        mc_n      = first ? s_axis_tdata[0] : mc_q;
        accept    = promisc | uc_n | (accept_bcast & bc_n) | (accept_mcast & mc_n);
        hdr_shift = {s_axis_tdata, hdr_q[5:1]};
        pend_n    = s_axis_tvalid ? ~s_axis_tlast : ovr_pend_q;
    end

    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        uc_d       = uc_q;
        bc_d       = bc_q;
        mc_d       = mc_q;
        tuser_d    = tuser_q;
        ovr_pend_d = ovr_pend_q;
        ovr_d      = ovr_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = 1'b0;
        m_tlast_d  = 1'b0;
        m_tuser_d  = 1'b0;
        inc_acc    = 1'b0;
        inc_drop   = 1'b0;
        inc_runt   = 1'b0;
        inc_bad    = 1'b0;
        inc_ovr    = 1'b0;
        unique case (state_q)
            StIdle, StHdr: begin
                if (s_axis_tvalid) begin
                    hdr_d = hdr_shift;
                    uc_d  = uc_n;
                    bc_d  = bc_n;
                    mc_d  = mc_n;
                    if (idx_q == 3'd5) begin
                        idx_d = 3'd0;
                        ovr_d = 1'b0;
                        if (s_axis_tlast) begin
                            if (accept) begin
                                tuser_d = s_axis_tuser;
                                fcnt_d  = 3'd0;
                                state_d = StFlush;
                            end else begin
                                inc_drop = 1'b1;
                                state_d  = StIdle;
                            end
                        end else begin
                            state_d = accept ? StPass : StDrop;
                        end
                    end else if (s_axis_tlast) begin
                        inc_runt = 1'b1;
                        idx_d    = 3'd0;
                        uc_d     = 1'b0;
                        bc_d     = 1'b0;
                        mc_d     = 1'b0;
                        state_d  = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StHdr;
                    end
                end
            end
            StPass: begin
                if (s_axis_tvalid) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = hdr_q[0];
                    hdr_d      = hdr_shift;
                    if (s_axis_tlast) begin
                        tuser_d = s_axis_tuser;
                        fcnt_d  = 3'd0;
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = hdr_q[0];
                hdr_d      = {8'h00, hdr_q[5:1]};
                fcnt_d     = fcnt_q + 3'd1;
                // A whole frame squeezed into the flush window is lost on the spot.
                if (s_axis_tvalid && s_axis_tlast) inc_ovr = 1'b1;
                ovr_pend_d = pend_n;
                if (fcnt_q == 3'd5) begin
                    m_tlast_d  = 1'b1;
                    m_tuser_d  = tuser_q;
                    inc_acc    = 1'b1;
                    inc_bad    = tuser_q;
                    fcnt_d     = 3'd0;
                    ovr_pend_d = 1'b0;
                    ovr_d      = pend_n;
                    state_d    = pend_n ? StDrop : StIdle;
                end
            end
            StDrop: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    inc_ovr  = ovr_q;
                    inc_drop = ~ovr_q;
                    ovr_d    = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hdr_q      <= '0;
            idx_q      <= 3'd0;
            fcnt_q     <= 3'd0;
            uc_q       <= 1'b0;
            bc_q       <= 1'b0;
            mc_q       <= 1'b0;
            tuser_q    <= 1'b0;
            ovr_pend_q <= 1'b0;
            ovr_q      <= 1'b0;
            m_tdata_q  <= 8'h00;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
            acc_q      <= '0;
            drop_q     <= '0;
            runt_q     <= '0;
            bad_q      <= '0;
            ovr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            uc_q       <= uc_d;
            bc_q       <= bc_d;
            mc_q       <= mc_d;
            tuser_q    <= tuser_d;
            ovr_pend_q <= ovr_pend_d;
            ovr_q      <= ovr_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
            acc_q      <= sat_inc(acc_q, inc_acc);
            drop_q     <= sat_inc(drop_q, inc_drop);
            runt_q     <= sat_inc(runt_q, inc_runt);
            bad_q      <= sat_inc(bad_q, inc_bad);
            ovr_cnt_q  <= sat_inc(ovr_cnt_q, inc_ovr);
        end
    end

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign cnt_accepted  = acc_q;
    assign cnt_dropped   = drop_q;
    assign cnt_runt      = runt_q;
    assign cnt_bad       = bad_q;
    assign cnt_overrun   = ovr_cnt_q;

endmodule
